// File: rtl/rgb_fade_seq.sv
// rgb_fade_seq: four-entry RGB565 palette sequencer that fades, holds, then advances to the next colour.
// Optional RGB_GAMMA_EN adds a registered square-law (ch*ch)>>8 output stage.
`timescale 1ns/1ps
`default_nettype none

module rgb_fade_seq #(
   parameter int TICK_DIV   = 100000,
   parameter int HOLD_STEPS = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load_in,
   input  logic [1:0]  addr_in,
   input  logic [15:0] color_in,
   input  logic        run_in,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out,
   output logic [1:0]  idx_out,
   output logic        busy_out
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FADE = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   pal_q [4];
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          busy_q, busy_d;

   logic          tick;
   logic [15:0]   tgt_color;
   logic [7:0]    tgt_r, tgt_g, tgt_b;
   logic          at_target;

   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   assign tick      = run_in && (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
   assign tgt_color = pal_q[idx_q];
   assign tgt_r     = {tgt_color[15:11], 3'b000};
   assign tgt_g     = {tgt_color[10:5], 2'b00};
   assign tgt_b     = {tgt_color[4:0], 3'b000};
   assign at_target = (r_q == tgt_r) && (g_q == tgt_g) && (b_q == tgt_b);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 4; i++)
            pal_q[i] <= 16'h0000;
      end else if (load_in) begin
         pal_q[addr_in] <= color_in;
      end
   end

   // With run_in low outside IDLE every register simply keeps its value.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
      if (state_q == S_IDLE) begin
         if (run_in) begin
            state_d    = S_FADE;
            idx_d      = 2'd0;
            tick_cnt_d = '0;
         end
      end else if (run_in) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
         if (tick) begin
            case (state_q)
               S_FADE: begin
                  if (at_target) begin
                     state_d    = S_HOLD;
                     hold_cnt_d = '0;
                  end else begin
                     r_d = step_toward(r_q, tgt_r);
                     g_d = step_toward(g_q, tgt_g);
                     b_d = step_toward(b_q, tgt_b);
                  end
               end
               S_HOLD: begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     hold_cnt_d = '0;
                     idx_d      = idx_q + 2'd1;
                     state_d    = S_FADE;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy_d = (state_d == S_FADE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         hold_cnt_q <= '0;
         idx_q      <= 2'd0;
         r_q        <= 8'd0;
         g_q        <= 8'd0;
         b_q        <= 8'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         idx_q      <= idx_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
      end
   end

   assign idx_out  = idx_q;
   assign busy_out = busy_q;

`ifdef RGB_GAMMA_EN
   function automatic logic [7:0] gamma_sq(input logic [7:0] c);
      logic [15:0] p;
      p = c * c;
      return p[15:8];
   endfunction

   logic [7:0] r_gam_q, g_gam_q, b_gam_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_gam_q <= 8'd0;
         g_gam_q <= 8'd0;
         b_gam_q <= 8'd0;
      end else begin
         r_gam_q <= gamma_sq(r_q);
         g_gam_q <= gamma_sq(g_q);
         b_gam_q <= gamma_sq(b_q);
      end
   end

   assign r_out = r_gam_q;
   assign g_out = g_gam_q;
   assign b_out = b_gam_q;
`else
   assign r_out = r_q;
   assign g_out = g_q;
   assign b_out = b_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgb_fade_seq.sv
// tb_rgb_fade_seq: directed checks of rgb_fade_seq with TICK_DIV=4, HOLD_STEPS=2 (default build).
`timescale 1ns/1ps
`default_nettype none

module tb_rgb_fade_seq;

   logic        CLK = 1'b0;
   logic        RST;
   logic        load_in;
   logic [1:0]  addr_in;
   logic [15:0] color_in;
   logic        run_in;
   logic [7:0]  r_out, g_out, b_out;
   logic [1:0]  idx_out;
   logic        busy_out;

   int tests = 0;
   int fails = 0;

   rgb_fade_seq #(
      .TICK_DIV   (4),
      .HOLD_STEPS (2)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .load_in  (load_in),
      .addr_in  (addr_in),
      .color_in (color_in),
      .run_in   (run_in),
      .r_out    (r_out),
      .g_out    (g_out),
      .b_out    (b_out),
      .idx_out  (idx_out),
      .busy_out (busy_out)
   );

   always #5 CLK = ~CLK;

   // Called on a negedge; the write lands on the following rising edge.
   task automatic write_pal(input logic [1:0] a, input logic [15:0] c);
      load_in  = 1'b1;
      addr_in  = a;
      color_in = c;
      @(negedge CLK);
      load_in  = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; load_in = 1'b0; addr_in = 2'd0; color_in = 16'h0; run_in = 1'b0;
      #1;
      tests++;
      if ({r_out, g_out, b_out, idx_out, busy_out} !== 27'h0) begin
         fails++;
         $display("FAIL reset_async: got %h want %h", {r_out, g_out, b_out, idx_out, busy_out}, 27'h0);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      tests++;
      if ({r_out, g_out, b_out, idx_out, busy_out} !== 27'h0) begin
         fails++;
         $display("FAIL reset_idle: got %h want %h", {r_out, g_out, b_out, idx_out, busy_out}, 27'h0);
      end
   endtask

   task automatic test_fade_up();
      write_pal(2'd0, 16'hF800);
      write_pal(2'd1, 16'h0000);
      run_in = 1'b1;
      @(negedge CLK);
      tests++;
      if ({busy_out, r_out} !== {1'b1, 8'h00}) begin
         fails++;
         $display("FAIL fade_start: got busy=%b r=%h want busy=1 r=00", busy_out, r_out);
      end
      for (int k = 1; k <= 248; k++) begin
         repeat (3) @(negedge CLK);
         tests++;
         if (r_out !== 8'(k - 1)) begin
            fails++;
            $display("FAIL fade_up_phase k=%0d: got %h want %h", k, r_out, 8'(k - 1));
         end
         @(negedge CLK);
         tests++;
         if ({r_out, g_out, b_out} !== {8'(k), 16'h0}) begin
            fails++;
            $display("FAIL fade_up k=%0d: got %h want %h", k, {r_out, g_out, b_out}, {8'(k), 16'h0});
         end
         if (k == 128) begin
            tests++;
            if (r_out !== 8'h80) begin
               fails++;
               $display("FAIL gamma_bypass: got %h want 80", r_out);
            end
         end
      end
      repeat (3) @(negedge CLK);
      tests++;
      if (busy_out !== 1'b1) begin
         fails++;
         $display("FAIL busy_before_fall: got %b want 1", busy_out);
      end
      @(negedge CLK);
      tests++;
      if ({busy_out, r_out} !== {1'b0, 8'hF8}) begin
         fails++;
         $display("FAIL busy_fall: got busy=%b r=%h want busy=0 r=f8", busy_out, r_out);
      end
   endtask

   task automatic test_hold_to_next();
      repeat (7) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out} !== {2'd0, 1'b0}) begin
         fails++;
         $display("FAIL hold_length: got idx=%0d busy=%b want idx=0 busy=0", idx_out, busy_out);
      end
      @(negedge CLK);
      tests++;
      if ({idx_out, busy_out, r_out} !== {2'd1, 1'b1, 8'hF8}) begin
         fails++;
         $display("FAIL hold_advance: got idx=%0d busy=%b r=%h want idx=1 busy=1 r=f8", idx_out, busy_out, r_out);
      end
      for (int k = 1; k <= 248; k++) begin
         repeat (4) @(negedge CLK);
         tests++;
         if (r_out !== 8'(248 - k)) begin
            fails++;
            $display("FAIL fade_down k=%0d: got %h want %h", k, r_out, 8'(248 - k));
         end
      end
   endtask

   task automatic test_wrap();
      repeat (12) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out} !== {2'd2, 1'b1}) begin
         fails++;
         $display("FAIL wrap_idx2: got idx=%0d busy=%b want idx=2 busy=1", idx_out, busy_out);
      end
      repeat (4) @(negedge CLK);
      tests++;
      if (busy_out !== 1'b0) begin
         fails++;
         $display("FAIL wrap_hold2: got busy=%b want 0", busy_out);
      end
      repeat (8) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out} !== {2'd3, 1'b1}) begin
         fails++;
         $display("FAIL wrap_idx3: got idx=%0d busy=%b want idx=3 busy=1", idx_out, busy_out);
      end
      repeat (12) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out, r_out} !== {2'd0, 1'b1, 8'h00}) begin
         fails++;
         $display("FAIL wrap_idx0: got idx=%0d busy=%b r=%h want idx=0 busy=1 r=00", idx_out, busy_out, r_out);
      end
      repeat (4) @(negedge CLK);
      tests++;
      if (r_out !== 8'h01) begin
         fails++;
         $display("FAIL wrap_refade: got %h want 01", r_out);
      end
   endtask

   task automatic test_freeze();
      repeat (2) @(negedge CLK);
      run_in = 1'b0;
      repeat (100) @(negedge CLK);
      tests++;
      if ({r_out, g_out, b_out, idx_out, busy_out} !== {8'h01, 16'h0, 2'd0, 1'b1}) begin
         fails++;
         $display("FAIL freeze_hold: got %h want %h", {r_out, g_out, b_out, idx_out, busy_out}, {8'h01, 16'h0, 2'd0, 1'b1});
      end
      run_in = 1'b1;
      @(negedge CLK);
      tests++;
      if (r_out !== 8'h01) begin
         fails++;
         $display("FAIL freeze_phase_pre: got %h want 01", r_out);
      end
      @(negedge CLK);
      tests++;
      if (r_out !== 8'h02) begin
         fails++;
         $display("FAIL freeze_phase_resume: got %h want 02", r_out);
      end
   endtask

   task automatic test_retarget();
      write_pal(2'd0, 16'h0000);
      repeat (3) @(negedge CLK);
      tests++;
      if (r_out !== 8'h01) begin
         fails++;
         $display("FAIL retarget_down: got %h want 01", r_out);
      end
      repeat (4) @(negedge CLK);
      tests++;
      if (r_out !== 8'h00) begin
         fails++;
         $display("FAIL retarget_zero: got %h want 00", r_out);
      end
      repeat (4) @(negedge CLK);
      tests++;
      if (busy_out !== 1'b0) begin
         fails++;
         $display("FAIL retarget_hold: got busy=%b want 0", busy_out);
      end
   endtask

   task automatic test_layout();
      write_pal(2'd1, 16'h0021);
      repeat (7) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out, g_out, b_out} !== {2'd1, 1'b1, 16'h0000}) begin
         fails++;
         $display("FAIL layout_enter: got idx=%0d busy=%b g=%h b=%h want idx=1 busy=1 g=00 b=00", idx_out, busy_out, g_out, b_out);
      end
      repeat (16) @(negedge CLK);
      tests++;
      if ({r_out, g_out, b_out} !== {8'h00, 8'h04, 8'h04}) begin
         fails++;
         $display("FAIL layout_four: got %h want 000404", {r_out, g_out, b_out});
      end
      repeat (4) @(negedge CLK);
      tests++;
      if ({busy_out, g_out, b_out} !== {1'b1, 8'h04, 8'h05}) begin
         fails++;
         $display("FAIL layout_no_overshoot: got busy=%b g=%h b=%h want busy=1 g=04 b=05", busy_out, g_out, b_out);
      end
   endtask

   task automatic test_reset_mid();
      #1 RST = 1'b1;
      #1;
      tests++;
      if ({r_out, g_out, b_out, idx_out, busy_out} !== 27'h0) begin
         fails++;
         $display("FAIL reset_mid_async: got %h want %h", {r_out, g_out, b_out, idx_out, busy_out}, 27'h0);
      end
      run_in = 1'b0;
      #1 RST = 1'b0;
      repeat (20) @(negedge CLK);
      tests++;
      if ({r_out, g_out, b_out, idx_out, busy_out} !== 27'h0) begin
         fails++;
         $display("FAIL reset_mid_idle: got %h want %h", {r_out, g_out, b_out, idx_out, busy_out}, 27'h0);
      end
      run_in = 1'b1;
      @(negedge CLK);
      tests++;
      if ({idx_out, busy_out} !== {2'd0, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_restart: got idx=%0d busy=%b want idx=0 busy=1", idx_out, busy_out);
      end
      repeat (16) @(negedge CLK);
      tests++;
      if ({idx_out, busy_out, g_out, b_out} !== {2'd1, 1'b0, 16'h0000}) begin
         fails++;
         $display("FAIL reset_palette_cleared: got idx=%0d busy=%b g=%h b=%h want idx=1 busy=0 g=00 b=00", idx_out, busy_out, g_out, b_out);
      end
   endtask

   initial begin
      test_reset();
      test_fade_up();
      test_hold_to_next();
      test_wrap();
      test_freeze();
      test_retarget();
      test_layout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
